// File: rtl/aes_key_schedule.sv
// AES key expansion for 128/192/256-bit keys: builds the full word schedule one word
// per cycle and serves 128-bit round keys from the stored words.

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] sub_c
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254, then the affine transform.
  always_comb begin
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sub_c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_ready,
  output logic         err,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid
);
  localparam int unsigned NUM_WORDS = (MAX_KEY_BITS <= 128) ? 44 :
                                      (MAX_KEY_BITS <= 192) ? 52 : 60;
  localparam int unsigned AW = 6;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  state_t state, next_state;

  logic [31:0]    w [NUM_WORDS];
  logic [255:0]   key_q;
  logic [1:0]     len_q;
  logic [AW-1:0]  idx, last_idx, rbase;
  logic [2:0]     phase;
  logic [7:0]     rcon;
  logic [3:0]     nk, nr;
  logic           legal, accept, reject, last_word, rd_acc;
  logic           busy_c, done_c;
  logic [31:0]    prev_w, back_w, sub_in, sub_out, temp_w, new_w;

  always_comb begin
    case (key_len)
      2'd0:    legal = 1'b1;
      2'd1:    legal = (MAX_KEY_BITS >= 32'd192);
      2'd2:    legal = (MAX_KEY_BITS >= 32'd256);
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && start && legal;
  assign reject = (state == IDLE) && start && !legal;

  always_comb begin
    case (len_q)
      2'd1:    begin nk = 4'd6; nr = 4'd12; end
      2'd2:    begin nk = 4'd8; nr = 4'd14; end
      default: begin nk = 4'd4; nr = 4'd10; end
    endcase
  end

  assign last_idx  = {nr, 2'b00} + AW'(3);
  assign last_word = (idx == last_idx);

  // Word generator: phase tracks i mod Nk.
  assign prev_w = w[idx - AW'(1)];
  assign back_w = w[idx - AW'(nk)];
  assign sub_in = (phase == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.x(sub_in[8*b +: 8]), .sub_c(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp_w = prev_w;
    if (phase == 3'd0)                      temp_w = sub_out ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && phase == 3'd4)   temp_w = sub_out;
    new_w = back_w ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(nk)) w[j] <= key_q[255-32*j -: 32];
    end else if (state == EXPAND) begin
      w[idx] <= new_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      len_q <= 2'd0;
      idx   <= '0;
      phase <= 3'd0;
      rcon  <= 8'h01;
    end else begin
      if (accept) begin
        key_q <= key;
        len_q <= key_len;
      end
      if (state == LOAD) begin
        idx   <= AW'(nk);
        phase <= 3'd0;
        rcon  <= 8'h01;
      end else if (state == EXPAND) begin
        idx   <= idx + AW'(1);
        phase <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOAD;
      LOAD:    next_state = EXPAND;
      EXPAND:  if (last_word) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    if (next_state == LOAD || next_state == EXPAND) busy_c = 1'b1;
    if (next_state == DONE)                         done_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      busy <= busy_c;
      done <= done_c;
      err  <= reject;
      if (accept)      key_ready <= 1'b0;
      else if (done_c) key_ready <= 1'b1;
    end
  end

  // Round-key read port; rounds past Nr read as zero.
  assign rd_acc = rd_en && key_ready;
  assign rbase  = {rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc)
        rd_key <= (rd_round > nr) ? 128'h0 :
                  {w[rbase], w[rbase + AW'(1)], w[rbase + AW'(2)], w[rbase + AW'(3)]};
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized and known-answer bench for aes_key_schedule against a table-driven
// FIPS-197 key expansion model.

module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst, start, rd_en;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         busy, done, key_ready, err, rd_valid;
  logic [127:0] rd_key;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] mw [60];

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .key_ready(key_ready), .err(err),
    .rd_en(rd_en), .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
  );

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb(v[31:24]), sb(v[23:16]), sb(v[15:8]), sb(v[7:0])};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {RCON[79-8*(i/nk-1) -: 8], 24'h000000};
      else if (nk == 8 && i % 8 == 4)
        t = sub_word(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int r, input int nk);
    if (r > nk + 6) return 128'h0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_expand(input logic [255:0] k, input logic [1:0] len, input string tag);
    int cnt;
    int nk;
    nk = 4 + 2*int'(len);
    model_expand(k, nk);
    key = k; key_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 128'(busy), 128'd1);
    cnt = 0;
    while (!done && cnt < 100) begin
      tick();
      cnt++;
    end
    check({tag, " latency"}, 128'(cnt), 128'(1 + 4*(nk+7) - nk));
    check({tag, " key_ready"}, 128'(key_ready), 128'd1);
  endtask

  task automatic read_one(input int r, input logic [127:0] exp, input string tag);
    rd_en = 1'b1; rd_round = 4'(r);
    tick();
    rd_en = 1'b0;
    check({tag, " valid"}, 128'(rd_valid), 128'd1);
    check({tag, " key"}, rd_key, exp);
  endtask

  // Back-to-back reads of every round index, then a hold check.
  task automatic read_all(input int nk, input string tag);
    rd_en = 1'b1;
    for (int r = 15; r >= 0; r--) begin
      rd_round = 4'(r);
      tick();
      check($sformatf("%s r%0d valid", tag, r), 128'(rd_valid), 128'd1);
      check($sformatf("%s r%0d", tag, r), rd_key, model_round(r, nk));
    end
    rd_en = 1'b0;
    tick();
    check({tag, " idle valid"}, 128'(rd_valid), 128'd0);
    check({tag, " hold"}, rd_key, model_round(0, nk));
  endtask

  initial begin
    logic [255:0] ka, kb;
    logic [127:0] last_exp;
    int cnt, dn, nk;
    logic [1:0] len;
    logic en;

    rst = 1'b1; start = 1'b0; rd_en = 1'b0; key_len = 2'd0; key = '0; rd_round = 4'd0;
    tick(); tick();
    check("rst busy", 128'(busy), 128'd0);
    check("rst done", 128'(done), 128'd0);
    check("rst key_ready", 128'(key_ready), 128'd0);
    check("rst err", 128'(err), 128'd0);
    check("rst rd_valid", 128'(rd_valid), 128'd0);
    check("rst rd_key", rd_key, 128'h0);

    rst = 1'b0; rd_en = 1'b1; rd_round = 4'd0;
    tick();
    rd_en = 1'b0;
    check("read before ready", 128'(rd_valid), 128'd0);

    rst = 1'b1; start = 1'b1; key_len = 2'd0;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst over start", 128'(busy), 128'd0);
    tick();
    check("rst over start 2", 128'(busy), 128'd0);

    run_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, "k128");
    read_one(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128 r10");
    read_one(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "k128 r0");
    read_all(4, "k128");

    run_expand({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'd1, "k192");
    read_one(12, 128'he98ba06f448c773c8ecc720401002202, "k192 r12");
    read_all(6, "k192");

    run_expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'd2, "k256");
    read_one(14, 128'hfe4890d1e6188d0b046df344706c631e, "k256 r14");
    read_one(15, 128'h0, "k256 r15");
    read_all(8, "k256");

    run_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 2'd0, "k128b");
    read_one(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k128b r10");
    key = {8{$urandom()}}; key_len = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("illegal err", 128'(err), 128'd1);
    check("illegal key_ready", 128'(key_ready), 128'd1);
    check("illegal busy", 128'(busy), 128'd0);
    tick();
    check("illegal err pulse", 128'(err), 128'd0);
    check("illegal stays idle", 128'(busy), 128'd0);
    read_one(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "illegal r10");

    // Reset 20 cycles into a 256-bit expansion.
    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom()};
    key_len = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 128'(busy), 128'd0);
    check("abort key_ready", 128'(key_ready), 128'd0);
    check("abort done", 128'(done), 128'd0);
    dn = 0;
    repeat (70) begin
      tick();
      if (done) dn++;
    end
    check("abort no done", 128'(dn), 128'd0);
    check("abort key_ready later", 128'(key_ready), 128'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("abort read ignored", 128'(rd_valid), 128'd0);

    // Start while busy must be ignored.
    ka = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    kb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom()};
    model_expand(ka, 4);
    key = ka; key_len = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    repeat (9) begin tick(); cnt++; end
    key = kb; key_len = 2'd2; start = 1'b1;
    tick(); cnt++;
    start = 1'b0;
    while (!done && cnt < 100) begin tick(); cnt++; end
    check("busy start latency", 128'(cnt), 128'd41);
    read_all(4, "busy start");

    for (int n = 0; n < 10; n++) begin
      len = 2'($urandom_range(0, 2));
      nk  = 4 + 2*int'(len);
      run_expand({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom()}, len, $sformatf("rnd%0d", n));
      read_all(nk, $sformatf("rnd%0d", n));
    end

    // Sparse random reads on the last schedule.
    last_exp = model_round(0, nk);
    for (int n = 0; n < 24; n++) begin
      en = 1'($urandom_range(0, 1));
      rd_en = en; rd_round = 4'($urandom_range(0, 15));
      if (en) last_exp = model_round(int'(rd_round), nk);
      tick();
      check($sformatf("sparse%0d valid", n), 128'(rd_valid), 128'(en));
      check($sformatf("sparse%0d key", n), rd_key, last_exp);
    end
    rd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256, meaning the largest supported key length (128, 192 or 256); it sizes the word store at 44, 52 or 60 words.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, meaning a request to begin expansion of key.
REQ-005 SHALL have port key_len, input, 2, meaning key length: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
REQ-006 SHALL have port key, input, 256, meaning the cipher key, MSB-aligned; 128-bit keys use [255:128] and 192-bit keys use [255:64].
REQ-007 SHALL have port busy, output, 1, meaning expansion is in progress.
REQ-008 SHALL have port done, output, 1, meaning a one-cycle pulse when expansion completes.
REQ-009 SHALL have port key_ready, output, 1, meaning the stored schedule is complete and readable.
REQ-010 SHALL have port err, output, 1, meaning a one-cycle pulse when start is rejected for an illegal length.
REQ-011 SHALL have port rd_en, input, 1, meaning a round-key read request.
REQ-012 SHALL have port rd_round, input, 4, meaning the round index for the read.
REQ-013 SHALL have port rd_key, output, 128, meaning the round key, with w[4r] in bits [127:96].
REQ-014 SHALL have port rd_valid, output, 1, meaning rd_key is valid this cycle.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, EXPAND and DONE, with the following transitions:
- IDLE -> LOAD on an accepted start.
- LOAD -> EXPAND after one cycle.
- EXPAND -> DONE after the last word is written.
- DONE -> IDLE after one cycle.
REQ-016 SHALL accept start only in IDLE with a legal key_len; start in any other state is ignored without side effects.
REQ-017 SHALL treat key_len = 11, and any length above MAX_KEY_BITS, as illegal: pulse err the next cycle, stay in IDLE, and leave the stored schedule and key_ready unchanged.
REQ-018 SHALL derive Nk = 4/6/8 and Nr = 10/12/14 from key_len, and latch key_len and key on acceptance.
REQ-019 SHALL clear key_ready on an accepted start and write w[0..Nk-1] from the latched key in LOAD.
REQ-020 SHALL generate exactly one 32-bit word per cycle in EXPAND, for i = Nk .. 4*(Nr+1)-1, using temp = w[i-1]:
- if i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {Rcon,24'h0};
- else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp);
- then w[i] = w[i-Nk] xor temp.
REQ-021 SHALL generate Rcon iteratively by GF(2^8) doubling (reduction 0x1b), starting at 01 and advancing each time i mod Nk = 0; the sequence is 01 02 04 08 10 20 40 80 1b 36.
REQ-022 SHALL implement SubWord as four instances of the team's combinational S-box.
REQ-023 SHALL assert done and key_ready in the same cycle, the DONE cycle, which is exactly 1 + 4*(Nr+1) - Nk cycles after the start-accept edge: 41, 47 or 53 cycles.
REQ-024 SHALL assert busy in LOAD and EXPAND only.
REQ-025 SHALL accept rd_en only while key_ready = 1; rd_en at other times is ignored and rd_valid stays 0.
REQ-026 SHALL, for an accepted read, drive rd_valid = 1 and rd_key = {w[4r], w[4r+1], w[4r+2], w[4r+3]} one cycle later; rd_valid is 0 otherwise.
REQ-027 SHALL return rd_key = 0 with rd_valid = 1 for an accepted read with rd_round > Nr.
REQ-028 SHALL sustain back-to-back reads, one per cycle.
REQ-029 SHALL hold rd_key at its last value when rd_valid = 0.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, enter IDLE and drive busy = 0, done = 0, key_ready = 0, err = 0, rd_valid = 0 and rd_key = 0.
REQ-031 SHALL let rst override start and rd_en in the same cycle.
REQ-032 SHALL abort an expansion in progress on reset; key_ready stays 0 until a new expansion completes.
REQ-033 SHALL not require the word store to be reset.

Verification
REQ-034 SHALL cover AES-128: key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c, start -> done 41 cycles later; read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; read round 0 -> the key itself.
REQ-035 SHALL cover AES-192: key[255:64] = 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
REQ-036 SHALL cover AES-256: key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles; round 14 = fe4890d1e6188d0b046df344706c631e; a read of round 15 returns 0 with rd_valid = 1.
REQ-037 SHALL cover AES-128: key = 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5; then start with key_len = 11 -> err pulse, key_ready stays 1, and round 10 is unchanged.
REQ-038 SHALL cover the following reset and ignore cases:
- rst asserted 20 cycles into an expansion -> busy = 0 and key_ready = 0 next cycle, with no done pulse.
- start asserted while busy -> ignored; done still arrives at the original cycle.
